// File: rtl/idct_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : idct_pkg
//  Purpose  : Shared constants and types for the 8-point 1-D inverse DCT.
//             Holds the data/coefficient/accumulator widths, the FSM state
//             encoding, the 32-entry MAC schedule table and the default
//             cosine coefficient values C0..C7.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package idct_pkg;

    localparam int IDCT_DW = 16;   // Q11.4 samples
    localparam int IDCT_CW = 16;   // Q0.15 coefficients
    localparam int IDCT_AW = 36;   // 32-bit product plus 4 guard bits

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One schedule step: subtract flag, coefficient index, input sample index.
    typedef struct packed {
        logic       sub;
        logic [2:0] cidx;
        logic [2:0] xidx;
    } tbl_entry_t;

    function automatic tbl_entry_t te(input logic s, input logic [2:0] c,
                                      input logic [2:0] x);
        tbl_entry_t r;
        r.sub  = s;
        r.cidx = c;
        r.xidx = x;
        return r;
    endfunction

    // Indexed by counter {pair[1:0], term[2:0]}. Terms 0..3 build the even
    // sum from X0/X2/X4/X6, terms 4..7 the odd sum from X1/X3/X5/X7.
    localparam tbl_entry_t [0:31] IDCT_TBL = {
        // pair 0: n=0 / n=7
        te(1'b0, 3'd4, 3'd0), te(1'b0, 3'd2, 3'd2), te(1'b0, 3'd4, 3'd4), te(1'b0, 3'd6, 3'd6),
        te(1'b0, 3'd1, 3'd1), te(1'b0, 3'd3, 3'd3), te(1'b0, 3'd5, 3'd5), te(1'b0, 3'd7, 3'd7),
        // pair 1: n=1 / n=6
        te(1'b0, 3'd4, 3'd0), te(1'b0, 3'd6, 3'd2), te(1'b1, 3'd4, 3'd4), te(1'b1, 3'd2, 3'd6),
        te(1'b0, 3'd3, 3'd1), te(1'b1, 3'd7, 3'd3), te(1'b1, 3'd1, 3'd5), te(1'b1, 3'd5, 3'd7),
        // pair 2: n=2 / n=5
        te(1'b0, 3'd4, 3'd0), te(1'b1, 3'd6, 3'd2), te(1'b1, 3'd4, 3'd4), te(1'b0, 3'd2, 3'd6),
        te(1'b0, 3'd5, 3'd1), te(1'b1, 3'd1, 3'd3), te(1'b0, 3'd7, 3'd5), te(1'b0, 3'd3, 3'd7),
        // pair 3: n=3 / n=4
        te(1'b0, 3'd4, 3'd0), te(1'b1, 3'd2, 3'd2), te(1'b0, 3'd4, 3'd4), te(1'b1, 3'd6, 3'd6),
        te(1'b0, 3'd7, 3'd1), te(1'b1, 3'd5, 3'd3), te(1'b0, 3'd3, 3'd5), te(1'b1, 3'd1, 3'd7)
    };

    // Ck = 0.5*cos(k*pi/16) in Q0.15; C0 carries the C4 value.
    localparam logic [0:7][IDCT_CW-1:0] COS_DEFAULT = {
        16'h2D41, 16'h3EC5, 16'h3B21, 16'h3537,
        16'h2D41, 16'h238E, 16'h187E, 16'h0C7C
    };

endpackage
`default_nettype wire

// File: rtl/idct_mac.sv
`default_nettype none
// ============================================================================
//  Module   : idct_mac
//  Purpose  : Time-shared multiply-accumulate for the 1-D IDCT. One signed
//             DW x CW product per cycle, registered, then added to or
//             subtracted from the even (terms 0..3) or odd (terms 4..7)
//             accumulator. The first term of each half reloads its
//             accumulator instead of adding, which clears it per pair.
//  Ports    : clk, rst_n      clock / async active-low reset
//             valid_i         a schedule step is being issued this cycle
//             sub_i           subtract the product instead of adding it
//             term_i, pair_i  schedule position of the issued step
//             a_i, b_i        sample (Q11.4) and coefficient (Q0.15)
//             e_d_o, o_d_o    next-state even/odd sums (include current step)
//             fin_o, pair_o   last term of a pair is being accumulated
//  Revision : 1.0  initial release
// ============================================================================
module idct_mac #(
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int AW = 36
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    input  logic                 sub_i,
    input  logic [2:0]           term_i,
    input  logic [1:0]           pair_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [CW-1:0] b_i,
    output logic signed [AW-1:0] e_d_o,
    output logic signed [AW-1:0] o_d_o,
    output logic                 fin_o,
    output logic [1:0]           pair_o
);

    localparam int PW = DW + CW;

    logic signed [PW-1:0] w_a;
    logic signed [PW-1:0] w_b;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] prod_q;
    logic                 vld_q;
    logic                 sub_q;
    logic [2:0]           term_q;
    logic [1:0]           pair_q;

    logic signed [AW-1:0] w_prod_ext;
    logic signed [AW-1:0] w_addend;
    logic signed [AW-1:0] e_q;
    logic signed [AW-1:0] e_d;
    logic signed [AW-1:0] o_q;
    logic signed [AW-1:0] o_d;

    assign w_a    = PW'(a_i);
    assign w_b    = PW'(b_i);
    assign w_prod = w_a * w_b;

    assign w_prod_ext = AW'(prod_q);
    assign w_addend   = sub_q ? -w_prod_ext : w_prod_ext;

    always_comb begin
        e_d = e_q;
        o_d = o_q;
        if (vld_q) begin
            if (!term_q[2]) begin
                e_d = ((term_q[1:0] == 2'd0) ? '0 : e_q) + w_addend;
            end else begin
                o_d = ((term_q[1:0] == 2'd0) ? '0 : o_q) + w_addend;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            vld_q  <= 1'b0;
            sub_q  <= 1'b0;
            term_q <= '0;
            pair_q <= '0;
            e_q    <= '0;
            o_q    <= '0;
        end else begin
            prod_q <= w_prod;
            vld_q  <= valid_i;
            sub_q  <= sub_i;
            term_q <= term_i;
            pair_q <= pair_i;
            e_q    <= e_d;
            o_q    <= o_d;
        end
    end

    assign e_d_o  = e_d;
    assign o_d_o  = o_d;
    assign fin_o  = vld_q && (term_q == 3'd7);
    assign pair_o = pair_q;

endmodule
`default_nettype wire

// File: rtl/idct_1d.sv
`default_nettype none
// ============================================================================
//  Module   : idct_1d
//  Purpose  : 8-point 1-D inverse DCT, Q11.4 in / Q11.4 out, using even/odd
//             decomposition and a single time-shared multiplier (32 MAC
//             cycles per transform, 35 cycles start-to-start).
//  Config   : IDCT_SAT_EN  defined   -> out-of-range results clamp to
//                                       0x7FFF / 0x8000
//                          undefined -> low DW bits kept (wrap-around)
//  Ports    : clk, clr_n          clock / async active-low reset
//             coef_in/sel/we      cosine coefficient bank write (idle only)
//             start, X0..X7       begin transform; inputs sampled on start
//             busy, done          in progress / one-cycle results-valid pulse
//             x0..x7              spatial-domain results
//  Revision : 1.0  initial release
// ============================================================================
module idct_1d
    import idct_pkg::*;
#(
    parameter int DW = IDCT_DW,
    parameter int CW = IDCT_CW,
    parameter int AW = IDCT_AW
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic [CW-1:0] coef_in,
    input  logic [2:0]    coef_sel,
    input  logic          coef_we,
    input  logic          start,
    input  logic [DW-1:0] X0,
    input  logic [DW-1:0] X1,
    input  logic [DW-1:0] X2,
    input  logic [DW-1:0] X3,
    input  logic [DW-1:0] X4,
    input  logic [DW-1:0] X5,
    input  logic [DW-1:0] X6,
    input  logic [DW-1:0] X7,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] x0,
    output logic [DW-1:0] x1,
    output logic [DW-1:0] x2,
    output logic [DW-1:0] x3,
    output logic [DW-1:0] x4,
    output logic [DW-1:0] x5,
    output logic [DW-1:0] x6,
    output logic [DW-1:0] x7
);

    // Product carries 19 fraction bits; dropping CW-1 leaves Q11.4.
    localparam int                   FRAC_SHIFT = CW - 1;
    localparam logic signed [AW-1:0] RND_HALF   = AW'(2 ** (CW - 2));
`ifdef IDCT_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX    = AW'(2 ** (DW - 1) - 1);
    localparam logic signed [AW-1:0] SAT_MIN    = -SAT_MAX - AW'(1);
`endif

    state_t               state_q;
    state_t               state_d;
    logic [4:0]           cnt_q;
    logic [4:0]           cnt_d;
    logic [CW-1:0]        coef_q [0:7];
    logic signed [DW-1:0] xin_q  [0:7];
    logic [DW-1:0]        xo_q   [0:7];

    logic                 w_idle;
    logic                 w_accept;
    tbl_entry_t           w_ent;
    logic signed [AW-1:0] w_e_d;
    logic signed [AW-1:0] w_o_d;
    logic                 w_fin;
    logic [1:0]           w_pair;
    logic [2:0]           w_lo_idx;
    logic [2:0]           w_hi_idx;

    assign w_idle   = (state_q == ST_IDLE);
    assign w_accept = w_idle && start;
    assign w_ent    = IDCT_TBL[cnt_q];

    // Round half up, then narrow to DW (clamp or wrap per build option).
    function automatic logic [DW-1:0] rnd_narrow(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] r;
        r = (v + RND_HALF) >>> FRAC_SHIFT;
`ifdef IDCT_SAT_EN
        if (r > SAT_MAX) begin
            return {1'b0, {(DW-1){1'b1}}};
        end else if (r < SAT_MIN) begin
            return {1'b1, {(DW-1){1'b0}}};
        end else begin
            return DW'(r);
        end
`else
        return DW'(r);
`endif
    endfunction

    // ------------------------------------------------------------------
    // Sequencer: 32 RUN cycles issue the schedule, FLUSH drains the
    // product register so pair 3 can be written, DONE pulses done.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = 5'd0;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Coefficient bank; writes are only honoured while idle, so a write
    // coinciding with an accepted start is visible to that transform.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < 8; i++) begin
                coef_q[i] <= '0;
            end
        end else if (coef_we && w_idle) begin
            coef_q[coef_sel] <= coef_in;
        end
    end

    // Input latch
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < 8; i++) begin
                xin_q[i] <= '0;
            end
        end else if (w_accept) begin
            xin_q[0] <= X0;
            xin_q[1] <= X1;
            xin_q[2] <= X2;
            xin_q[3] <= X3;
            xin_q[4] <= X4;
            xin_q[5] <= X5;
            xin_q[6] <= X6;
            xin_q[7] <= X7;
        end
    end

    idct_mac #(
        .DW (DW),
        .CW (CW),
        .AW (AW)
    ) u_mac (
        .clk     (clk),
        .rst_n   (clr_n),
        .valid_i (state_q == ST_RUN),
        .sub_i   (w_ent.sub),
        .term_i  (cnt_q[2:0]),
        .pair_i  (cnt_q[4:3]),
        .a_i     (xin_q[w_ent.xidx]),
        .b_i     (coef_q[w_ent.cidx]),
        .e_d_o   (w_e_d),
        .o_d_o   (w_o_d),
        .fin_o   (w_fin),
        .pair_o  (w_pair)
    );

    assign w_lo_idx = {1'b0, w_pair};
    assign w_hi_idx = 3'd7 - w_lo_idx;

    // Results are taken from the accumulators' next state so the final
    // odd term is included on the same edge it is accumulated.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < 8; i++) begin
                xo_q[i] <= '0;
            end
        end else if (w_fin) begin
            xo_q[w_lo_idx] <= rnd_narrow(w_e_d + w_o_d);
            xo_q[w_hi_idx] <= rnd_narrow(w_e_d - w_o_d);
        end
    end

    assign busy = !w_idle;
    assign done = (state_q == ST_DONE);
    assign x0   = xo_q[0];
    assign x1   = xo_q[1];
    assign x2   = xo_q[2];
    assign x3   = xo_q[3];
    assign x4   = xo_q[4];
    assign x5   = xo_q[5];
    assign x6   = xo_q[6];
    assign x7   = xo_q[7];

endmodule
`default_nettype wire
